// File: rtl/sliced_alu_if.sv
// sliced_alu_if: control-side bus of the sliced ALU engine.
// master drives the operation request, the register load and the readout select.
// slave returns the readout data, busy/done status and the XNZVC flags.
interface sliced_alu_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
);
  localparam int SW = $clog2(NREGS);
  logic              start;
  logic [2:0]        op;
  logic [1:0]        size;
  logic [SW-1:0]     src_sel;
  logic [SW-1:0]     dst_sel;
  logic              load_en;
  logic [SW-1:0]     load_sel;
  logic [DATA_W-1:0] load_data;
  logic [SW-1:0]     rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [4:0]        flags;
  modport master (
    output start, op, size, src_sel, dst_sel, load_en, load_sel, load_data, rd_sel,
    input  rd_data, busy, done, flags
  );
  modport slave (
    input  start, op, size, src_sel, dst_sel, load_en, load_sel, load_data, rd_sel,
    output rd_data, busy, done, flags
  );
endinterface

// File: rtl/sliced_alu_engine.sv
// sliced_alu_engine: 68000-style dyadic datapath (Dsrc op Ddst -> Ddst) over a narrow ALU slice.
// Ports: CLK, RESET (sync, active-high); bus (sliced_alu_if.slave):
//   start/op/size/src_sel/dst_sel request, load_en/load_sel/load_data register load,
//   rd_sel/rd_data registered readout, busy/done status, flags {X,N,Z,V,C}.
module sliced_alu_engine #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int NREGS   = 8
) (
  input logic          CLK,
  input logic          RESET,
  sliced_alu_if.slave  bus
);
  localparam int SW = $clog2(NREGS);
  localparam int NS = DATA_W / SLICE_W;
  localparam int KW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        size_q, size_d;
  logic [SW-1:0]     src_sel_q, src_sel_d, dst_sel_q, dst_sel_d;
  logic [DATA_W-1:0] src_q, src_d, dst_q, dst_d, res_q, res_d;
  logic              cy_q, cy_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [4:0]        flags_q, flags_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d, done_q, done_d;
  function automatic logic msb(input logic [DATA_W-1:0] x, input logic [1:0] sz);
    return sz == 2'b00 ? x[7] : sz == 2'b01 ? x[15] : x[DATA_W-1];
  endfunction
  logic [31:0]        s_w, off;
  logic [DATA_W-1:0]  mask, r;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   cin_w, sum;
  logic               add_op, sub_op, x_op, logic_op, cin, cout, last, rn, ds, ss, v;
  assign s_w      = size_q == 2'b00 ? 32'd8 : size_q == 2'b01 ? 32'd16 : 32'd32;
  assign mask     = size_q == 2'b00 ? 32'h0000_00FF : size_q == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign off      = 32'(k_q) * SLICE_W;
  assign add_op   = op_q == 3'd0 || op_q == 3'd5;
  assign sub_op   = op_q == 3'd1 || op_q == 3'd6 || op_q == 3'd7;
  assign x_op     = op_q == 3'd5 || op_q == 3'd6;
  assign logic_op = !add_op && !sub_op;
  // Operands are masked to the operand size so that, for sizes narrower than
  // the slice, the carry/borrow out of bit S-1 shows up at bit S and above.
  assign a_sl     = dst_q[off +: SLICE_W] & mask[off +: SLICE_W];
  assign b_sl     = src_q[off +: SLICE_W] & mask[off +: SLICE_W];
  assign cin      = k_q == '0 ? (x_op & flags_q[4]) : cy_q;
  assign cin_w    = {{SLICE_W{1'b0}}, cin};
  assign sum      = add_op ? {1'b0, a_sl} + {1'b0, b_sl} + cin_w :
                    sub_op ? {1'b0, a_sl} - {1'b0, b_sl} - cin_w :
                    op_q == 3'd2 ? {1'b0, a_sl & b_sl} :
                    op_q == 3'd3 ? {1'b0, a_sl | b_sl} : {1'b0, a_sl ^ b_sl};
  assign cout     = s_w < SLICE_W ? |(sum >> s_w) : sum[SLICE_W];
  assign last     = s_w <= SLICE_W || 32'(k_q) == s_w / SLICE_W - 32'd1;
  assign r        = res_q & mask;
  assign rn       = msb(r, size_q);
  assign ds       = msb(dst_q, size_q);
  assign ss       = msb(src_q, size_q);
  assign v        = add_op ? (ds == ss) && (rn != ds) : sub_op ? (ds != ss) && (rn != ds) : 1'b0;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    size_d    = size_q;
    src_sel_d = src_sel_q;
    dst_sel_d = dst_sel_q;
    src_d     = src_q;
    dst_d     = dst_q;
    res_d     = res_q;
    cy_d      = cy_q;
    k_d       = k_q;
    regs_d    = regs_q;
    flags_d   = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.load_en) regs_d[bus.load_sel] = bus.load_data;
        if (bus.start) begin
          op_d      = bus.op;
          size_d    = bus.size;
          src_sel_d = bus.src_sel;
          dst_sel_d = bus.dst_sel;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        src_d   = regs_q[src_sel_q];
        dst_d   = regs_q[dst_sel_q];
        k_d     = '0;
        state_d = EXEC;
      end
      EXEC: begin
        res_d[off +: SLICE_W] = sum[SLICE_W-1:0];
        cy_d    = cout;
        k_d     = k_q + KW'(1);
        state_d = last ? WRITE : EXEC;
      end
      default: begin
        // ADDX/SUBX only ever clear Z, so multi-precision chains keep a valid Z.
        flags_d = {(add_op || sub_op) && op_q != 3'd7 ? cy_q : flags_q[4],
                   rn,
                   x_op ? (r == '0 ? flags_q[2] : 1'b0) : r == '0,
                   v,
                   logic_op ? 1'b0 : cy_q};
        if (op_q != 3'd7) regs_d[dst_sel_q] = (regs_q[dst_sel_q] & ~mask) | r;
        state_d = IDLE;
      end
    endcase
    // Reading the next-state file makes a writeback visible the cycle after done.
    rd_data_d = regs_d[bus.rd_sel];
    busy_d    = state_d != IDLE;
    done_d    = state_d == WRITE;
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q   <= IDLE;
      op_q      <= '0;
      size_q    <= '0;
      src_sel_q <= '0;
      dst_sel_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      res_q     <= '0;
      cy_q      <= 1'b0;
      k_q       <= '0;
      regs_q    <= '{default: '0};
      flags_q   <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      size_q    <= size_d;
      src_sel_q <= src_sel_d;
      dst_sel_q <= dst_sel_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      res_q     <= res_d;
      cy_q      <= cy_d;
      k_q       <= k_d;
      regs_q    <= regs_d;
      flags_q   <= flags_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.flags   = flags_q;
endmodule

// File: tb/tb_sliced_alu_engine.sv
// tb_sliced_alu_engine: table-driven scoreboard bench for sliced_alu_engine (SLICE_W=16).
module tb_sliced_alu_engine;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;
  sliced_alu_if #(.DATA_W(32), .NREGS(8)) bus ();
  sliced_alu_engine #(.DATA_W(32), .SLICE_W(16), .NREGS(8)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  typedef struct {
    logic [2:0]  src, dst;
    logic [31:0] sv, dv;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] exp_d;
    logic [4:0]  exp_f;
    int          lat;
  } vec_t;
  typedef struct {
    logic [2:0]  dst;
    logic [31:0] d;
    logic [4:0]  f;
    int          lat;
  } exp_t;
  vec_t vt [17];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ndone;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic load(input logic [2:0] sel, input logic [31:0] d);
    @(negedge CLK);
    bus.load_en = 1'b1;
    bus.load_sel = sel;
    bus.load_data = d;
    @(negedge CLK);
    bus.load_en = 1'b0;
  endtask
  task automatic run_op(input logic [2:0] src, input logic [2:0] dst, input logic [2:0] op,
                        input logic [1:0] size, input logic [31:0] exp_d, input logic [4:0] exp_f,
                        input int lat, input logic with_load, input logic [31:0] ld);
    int   cyc;
    exp_t e;
    @(negedge CLK);
    bus.start = 1'b1;
    bus.op = op;
    bus.size = size;
    bus.src_sel = src;
    bus.dst_sel = dst;
    bus.rd_sel = dst;
    bus.load_en = with_load;
    bus.load_sel = src;
    bus.load_data = ld;
    sb.push_back('{dst, exp_d, exp_f, lat});
    @(negedge CLK);
    bus.start = 1'b0;
    bus.load_en = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    e = sb.pop_front();
    chk("done_latency", 32'(cyc), 32'(e.lat));
    @(negedge CLK);
    chk("result", bus.rd_data, e.d);
    chk("flags", {27'd0, bus.flags}, {27'd0, e.f});
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
  endtask
  initial begin
    bus.start = 0; bus.op = 0; bus.size = 0; bus.src_sel = 0; bus.dst_sel = 0;
    bus.load_en = 0; bus.load_sel = 0; bus.load_data = 0; bus.rd_sel = 0;
    vt[0]  = '{0, 1, 32'h1,        32'h1,        3'd0, 2'b10, 32'h2,        5'b00000, 4};
    vt[1]  = '{0, 1, 32'h0000FFFF, 32'h1,        3'd0, 2'b10, 32'h00010000, 5'b00000, 4};
    vt[2]  = '{0, 1, 32'h80,       32'h12345680, 3'd0, 2'b00, 32'h12345600, 5'b10111, 3};
    vt[3]  = '{0, 1, 32'h7,        32'h5,        3'd7, 2'b01, 32'h5,        5'b11001, 3};
    vt[4]  = '{0, 1, 32'h1,        32'h8000,     3'd1, 2'b01, 32'h7FFF,     5'b00010, 3};
    vt[5]  = '{0, 1, 32'h1,        32'hAABBCC00, 3'd1, 2'b00, 32'hAABBCCFF, 5'b11001, 3};
    vt[6]  = '{2, 3, 32'h55AA55AA, 32'h55AA55AA, 3'd7, 2'b10, 32'h55AA55AA, 5'b10100, 4};
    vt[7]  = '{2, 3, 32'h0,        32'hFFFFFFFF, 3'd5, 2'b10, 32'h0,        5'b10101, 4};
    vt[8]  = '{4, 5, 32'h0,        32'h1,        3'd6, 2'b10, 32'h0,        5'b00100, 4};
    vt[9]  = '{6, 7, 32'h1,        32'h12347FFF, 3'd5, 2'b01, 32'h12348000, 5'b01010, 3};
    vt[10] = '{0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 2'b10, 32'hF000F000, 5'b01000, 4};
    vt[11] = '{2, 3, 32'h0F,       32'hABCDEF70, 3'd3, 2'b00, 32'hABCDEF7F, 5'b00000, 3};
    vt[12] = '{4, 5, 32'hFFFF,     32'h1111FFFF, 3'd4, 2'b01, 32'h11110000, 5'b00100, 3};
    vt[13] = '{1, 1, 32'h80000000, 32'h80000000, 3'd0, 2'b10, 32'h0,        5'b10111, 4};
    vt[14] = '{7, 6, 32'h0,        32'h0,        3'd6, 2'b00, 32'hFF,       5'b11001, 3};
    vt[15] = '{0, 1, 32'h1,        32'h00010000, 3'd1, 2'b10, 32'h0000FFFF, 5'b00000, 4};
    vt[16] = '{2, 3, 32'h1,        32'h7FFFFFFF, 3'd0, 2'b11, 32'h80000000, 5'b01010, 4};
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("reset_rd_data", bus.rd_data, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_flags", {27'd0, bus.flags}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      load(vt[i].src, vt[i].sv);
      if (vt[i].dst != vt[i].src) load(vt[i].dst, vt[i].dv);
      run_op(vt[i].src, vt[i].dst, vt[i].op, vt[i].size, vt[i].exp_d, vt[i].exp_f, vt[i].lat, 1'b0, 32'd0);
    end
    load(1, 32'd4);
    run_op(0, 1, 3'd0, 2'b10, 32'd7, 5'b00000, 4, 1'b1, 32'd3);
    load(0, 32'd5);
    load(1, 32'd6);
    load(4, 32'h44);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = 3'd0; bus.size = 2'b10; bus.src_sel = 0; bus.dst_sel = 1; bus.rd_sel = 1;
    @(negedge CLK);
    bus.start = 1'b0;
    chk("busy_in_fetch", {31'd0, bus.busy}, 32'd1);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = 3'd1;
    bus.load_en = 1'b1; bus.load_sel = 4; bus.load_data = 32'hDEAD;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      bus.start = 1'b0;
      bus.load_en = 1'b0;
      if (bus.done) ndone++;
    end
    chk("start_busy_ignored_dones", 32'(ndone), 32'd1);
    chk("start_busy_result", bus.rd_data, 32'd11);
    chk("start_busy_flags", {27'd0, bus.flags}, 32'd0);
    bus.rd_sel = 4;
    @(negedge CLK);
    chk("load_busy_dropped", bus.rd_data, 32'h44);
    load(2, 32'd9);
    load(3, 32'd3);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = 3'd0; bus.size = 2'b10; bus.src_sel = 2; bus.dst_sel = 3; bus.rd_sel = 3;
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    chk("busy_in_exec", {31'd0, bus.busy}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.done) ndone++;
    end
    chk("midreset_no_done", 32'(ndone), 32'd0);
    chk("midreset_dst", bus.rd_data, 32'd0);
    chk("midreset_flags", {27'd0, bus.flags}, 32'd0);
    bus.rd_sel = 2;
    @(negedge CLK);
    chk("midreset_src", bus.rd_data, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
